// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential fixed-point matrix multiplier.
// Defines the controller states, the walk-position record and the saturating writeback.
package matmul_pkg;

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MAC, S_WB, S_FIN} state_t;

   localparam int DIM_W = 32;
   typedef logic [DIM_W-1:0] dim_t;

   // Position of one output element: row/column plus the flat row offsets into A and B_T.
   typedef struct packed {
      dim_t i;
      dim_t j;
      dim_t a_base;
      dim_t b_base;
   } pos_t;

   function automatic int acc_width(input int dw, input int mbuf);
      return 2 * dw + $clog2(mbuf);
   endfunction

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Arithmetic shift by frac (rounds toward -inf), then clamp into the signed dw-bit range.
   function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                    input int frac, input int dw);
      logic signed [63:0] v, hi, lo;
      v  = acc >>> frac;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane with synchronous clear and enable.
// Output is the accumulator shifted, saturated to DW bits and optionally clipped by ReLU.
module mac_lane
   import matmul_pkg::*;
#(
   parameter int DW   = 16,
   parameter int FRAC = 8,
   parameter int ACCW = 36
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 relu,
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic signed [DW-1:0] q
);

   logic signed [ACCW-1:0] acc;
   logic signed [2*DW-1:0] prod;
   logic signed [DW-1:0]   sat;

   assign prod = (2*DW)'(a) * (2*DW)'(b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      acc <= '0;
      else if (clr) acc <= '0;
      else if (en)  acc <= acc + ACCW'(prod);
   end

   assign sat = DW'(sat_shift(64'(acc), FRAC, DW));
   assign q   = (relu && sat[DW-1]) ? '0 : sat;

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential L x M by M x N signed fixed-point matrix multiplier with LANES parallel MAC lanes.
// Controller walks output elements row-major, LANES at a time, m MAC cycles plus one writeback per pass.
module matrix_mult_seq
   import matmul_pkg::*;
#(
   parameter int LBUF  = 16,
   parameter int MBUF  = 16,
   parameter int NBUF  = 16,
   parameter int DW    = 16,
   parameter int FRAC  = 8,
   parameter int LANES = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     relu_en,
   input  logic [31:0]              l,
   input  logic [31:0]              m,
   input  logic [31:0]              n,
   input  logic [DW*LBUF*MBUF-1:0]  A,
   input  logic [DW*NBUF*MBUF-1:0]  B_T,
   output logic [DW*LBUF*NBUF-1:0]  result,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output state_t                   state_dbg
);

   localparam int ACCW = acc_width(DW, MBUF);
   localparam int A_N  = LBUF * MBUF;
   localparam int B_N  = NBUF * MBUF;
   localparam int R_N  = LBUF * NBUF;
   localparam int AIW  = idx_width(A_N);
   localparam int BIW  = idx_width(B_N);
   localparam int RIW  = idx_width(R_N);

   // Handshake: start is taken only in IDLE (busy low); busy stays high until the edge that raises
   // done for one cycle, and a start seen during that done cycle opens the next job.
   state_t state, state_nxt;
   dim_t   l_q, m_q, n_q, o_q, k_q;
   logic   relu_q, err_q;
   pos_t   base_q;
   pos_t   pos [LANES+1];

   logic [LANES-1:0]     lane_vld;
   logic signed [DW-1:0] a_arr [A_N];
   logic signed [DW-1:0] b_arr [B_N];
   logic signed [DW-1:0] res_arr [R_N];
   logic signed [DW-1:0] lane_a [LANES];
   logic signed [DW-1:0] lane_b [LANES];
   logic signed [DW-1:0] lane_q [LANES];
   logic reject, pass_last, lane_en, lane_clr;

   for (genvar g = 0; g < A_N; g++) begin : g_a
      assign a_arr[g] = A[g*DW +: DW];
   end
   for (genvar g = 0; g < B_N; g++) begin : g_b
      assign b_arr[g] = B_T[g*DW +: DW];
   end
   for (genvar g = 0; g < R_N; g++) begin : g_r
      assign result[g*DW +: DW] = res_arr[g];
   end

   assign reject = (l_q == '0) || (m_q == '0) || (n_q == '0) ||
                   (l_q > dim_t'(LBUF)) || (m_q > dim_t'(MBUF)) || (n_q > dim_t'(NBUF));

   // Each lane's position is the previous one stepped by a single element; pos[LANES] is the next base.
   always_comb begin
      pos[0] = base_q;
      for (int p = 0; p < LANES; p++) begin
         if (pos[p].j == n_q - dim_t'(1)) begin
            pos[p+1].i      = pos[p].i + dim_t'(1);
            pos[p+1].j      = '0;
            pos[p+1].a_base = pos[p].a_base + m_q;
            pos[p+1].b_base = '0;
         end else begin
            pos[p+1].i      = pos[p].i;
            pos[p+1].j      = pos[p].j + dim_t'(1);
            pos[p+1].a_base = pos[p].a_base;
            pos[p+1].b_base = pos[p].b_base + m_q;
         end
      end
      for (int p = 0; p < LANES; p++) begin
         lane_vld[p] = pos[p].i < l_q;
         lane_a[p]   = lane_vld[p] ? a_arr[AIW'(pos[p].a_base + k_q)] : '0;
         lane_b[p]   = lane_vld[p] ? b_arr[BIW'(pos[p].b_base + k_q)] : '0;
      end
   end

   assign pass_last = pos[LANES].i >= l_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start) state_nxt = S_CHECK;
         S_CHECK: state_nxt = reject ? S_FIN : S_MAC;
         S_MAC:   if (k_q == m_q - dim_t'(1)) state_nxt = S_WB;
         S_WB:    state_nxt = pass_last ? S_FIN : S_MAC;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != S_IDLE);
      lane_en  = (state == S_MAC);
      lane_clr = (state == S_WB) || (state == S_CHECK);
   end

   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_q    <= '0;
         m_q    <= '0;
         n_q    <= '0;
         o_q    <= '0;
         k_q    <= '0;
         relu_q <= 1'b0;
         err_q  <= 1'b0;
         base_q <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
         for (int r = 0; r < R_N; r++) res_arr[r] <= '0;
      end else begin
         done <= (state == S_FIN);
         err  <= (state == S_FIN) && err_q;
         case (state)
            S_IDLE: if (start) begin
               l_q    <= l;
               m_q    <= m;
               n_q    <= n;
               relu_q <= relu_en;
            end
            S_CHECK: begin
               err_q  <= reject;
               o_q    <= '0;
               k_q    <= '0;
               base_q <= '0;
               if (!reject)
                  for (int r = 0; r < R_N; r++) res_arr[r] <= '0;
            end
            S_MAC: k_q <= k_q + dim_t'(1);
            S_WB: begin
               k_q    <= '0;
               o_q    <= o_q + dim_t'(LANES);
               base_q <= pos[LANES];
               for (int p = 0; p < LANES; p++)
                  if (lane_vld[p]) res_arr[RIW'(o_q + dim_t'(p))] <= lane_q[p];
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      mac_lane #(.DW(DW), .FRAC(FRAC), .ACCW(ACCW)) u_lane (
         .clk  (clk),
         .rst  (rst),
         .clr  (lane_clr),
         .en   (lane_en && lane_vld[g]),
         .relu (relu_q),
         .a    (lane_a[g]),
         .b    (lane_b[g]),
         .q    (lane_q[g])
      );
   end

endmodule

// File: doc/matrix_mult_seq.md
Name: matrix_mult_seq

Overview:
Next-generation flexible matrix multiplier for the NN datapath. It computes RESULT = A × B, with A of size L×M and B of size M×N.
- Signed fixed-point operands; matrices are flat row-major vectors; B is supplied transposed (B_T, N×M).
- LANES parallel multiply-accumulate lanes each produce one output element per pass.
- Adds over the previous generation: start/busy/done handshake, async reset, dimension checking with an error flag, saturation, optional ReLU.

Parameters:
- LBUF, 16, maximum runtime L (rows of A).
- MBUF, 16, maximum runtime M (inner dimension).
- NBUF, 16, maximum runtime N (columns of B).
- DW, 16, signed operand/result width.
- FRAC, 8, fractional bits of the fixed-point format (Q(DW-FRAC).FRAC).
- LANES, 1, number of parallel MAC lanes; 1 ≤ LANES ≤ LBUF*NBUF.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when not busy.
- relu_en  in  1  apply ReLU on writeback; latched at accepted start.
- l  in  32  runtime L; latched at accepted start.
- m  in  32  runtime M; latched at accepted start.
- n  in  32  runtime N; latched at accepted start.
- A  in  DW*LBUF*MBUF  row-major A; element (i,k) at index i*m+k. Must be held stable while busy.
- B_T  in  DW*NBUF*MBUF  row-major B transposed; element (j,k) at index j*m+k. Must be held stable while busy.
- result  out  DW*LBUF*NBUF  row-major result; element (i,j) at index i*n+j.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualified by done; high = dimensions were rejected.

Behaviour:
- Reset (async): result=0, busy=0, done=0, err=0, state IDLE, all counters and accumulators 0. Asserting rst mid-operation aborts the job immediately; no done pulse is produced.
- States: IDLE, CHECK, MAC, WB, FIN.
- IDLE:
  - start=1 latches l, m, n and relu_en; busy←1; next state CHECK.
  - start while busy is ignored (no queueing).
- CHECK (1 cycle):
  - Reject if l=0, m=0, n=0, l>LBUF, m>MBUF or n>NBUF. On reject: done=1, err=1, busy=0 in the next cycle; state→IDLE; result is left unchanged.
  - Otherwise: clear all of result to 0, set output base index o=0 and k=0; state→MAC.
- MAC (m cycles per pass):
  - Lane p handles flat output index e=o+p, with row i=e/n and column j=e%n.
  - If e < l*n: acc_p += A(i,k)*B_T(j,k). Lanes with e ≥ l*n hold 0.
  - k increments each cycle; after k=m-1, state→WB.
- WB (1 cycle):
  - Each valid lane computes v = acc_p >>> FRAC (arithmetic shift, truncation toward −inf), saturates v to signed DW range [−2^(DW-1), 2^(DW-1)−1], then applies ReLU if latched relu_en=1 (v<0 → 0).
  - Each valid lane writes result[e]. Accumulators are cleared; o += LANES; k=0.
  - If o ≥ l*n: state→FIN. Otherwise state→MAC.
- FIN: done=1, err=0, busy=0 for exactly one cycle; state→IDLE. A start in the cycle where done=1 is accepted (back-to-back jobs).
- Latency, from the start-sampling edge to the done-high cycle: 2 + ceil(l*n/LANES)*(m+1) cycles. An error completes in 2 cycles.
- Widths:
  - Products are 2*DW bits.
  - Accumulator ACCW = 2*DW + clog2(MBUF) bits, so it never overflows internally.
  - Only the writeback saturates.
- Index arithmetic uses the latched 32-bit dimensions. i and j are tracked incrementally (j wraps at n, i increments on wrap), not by division.

Decomposition:
- Package matmul_pkg:
  - state enum;
  - ACCW derivation function;
  - sat_shift(acc, FRAC, DW) function;
  - flat-index helper constants.
- Sub-module mac_lane: one multiply-accumulator with clear, enable and saturating/ReLU writeback output. It is instantiated LANES times by matrix_mult_seq. The controller (FSM, counters, operand selection, result register) stays in the top module.

Test Plan:
1. DW=16, FRAC=8, LANES=1, l=m=n=2. A=I (0x0100,0,0,0x0100); B_T={0x0200,0x0400,0x0300,0x0500}. Expected: result={0x0200,0x0300,0x0400,0x0500}; done in cycle 14 after start; err=0.
2. LANES=2, l=2, m=3, n=1. A={1,2,3,−1,−1,−1}·0x0100; B_T={0x0100×3}. Expected: result={0x0600,0xFD00} with relu_en=0. A rerun with relu_en=1 gives {0x0600,0x0000}. Latency 6 cycles.
3. Saturation: l=m=n=1. 0x7F00×0x0200 → 0x7FFF. 0x8000×0x0200 → 0x8000.
4. Errors: m=0 gives done=1 and err=1 two cycles after start, with result unchanged. l=LBUF+1 gives the same response.
5. Reset: assert rst 3 cycles into a job. Expected: busy=0, done=0, result=0 immediately. Next start completes correctly, as in case 1.
6. Handshake: hold start high through an entire job. Expected: exactly one job per done pulse; a second job starts on the done cycle; dimension changes while busy do not affect the result.
